tetris_cmd_issuer: RTL

//  Command initiator for the tetris game core: turns debounced buttons, a gravity timer and

---
 rtl/tetris_cmd_issuer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_cmd_issuer.sv
// tetris_cmd_issuer: turns buttons, gravity and garbage requests
// into one-cycle commands for the tetris core.
//
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   btn[6:0]      {hold,drop,rot_rev,rot,down,right,left} levels
//   state         current core state
//   score         BCD score, drives the gravity level
//   rng           random source, [3:0] picks the garbage hole
//   bar_req       one-cycle pulse per incoming garbage line
//   ctrl          registered command to the core
//   bar_mask      one-hot hole column, valid with ctrl == BAR
//   level         current gravity level

package enum_type;
    typedef enum logic [3:0] {
        NONE,
        INIT,
        WAIT,
        END,
        MOVE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        ROTATE,
        ROTATE_REV,
        HOLD,
        BAR
    } state_type;
endpackage

module tetris_cmd_issuer
    import enum_type::*;
#(
    parameter int GRAVITY_TICKS = 50_000_000,
    parameter int MAX_SHIFT     = 4,
    parameter int DAS_TICKS     = 20_000_000,
    parameter int ARR_TICKS     = 5_000_000,
    parameter int BAR_MAX       = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  btn,
    input  state_type   state,
    input  logic [15:0] score,
    input  logic [31:0] rng,
    input  logic        bar_req,
    output state_type   ctrl,
    output logic [9:0]  bar_mask,
    output logic [2:0]  level
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } fsm_t;

    fsm_t        fsm_q;
    fsm_t        fsm_d;
    state_type   ctrl_d;
    logic [9:0]  mask_d;
    logic [6:0]  btn_q;
    logic [6:0]  pend_q;
    logic [6:0]  pend_set;
    logic [6:0]  pend_clr;
    logic [6:0]  rise;
    logic [31:0] rep_q [3];
    logic [2:0]  rep_fire;
    logic [31:0] grav_q;
    logic [31:0] per_q;
    logic        grav_fire;
    logic        grav_rst;
    logic        running;
    logic        wake;
    logic        bar_inc;
    logic        bar_dec;
    logic [4:0]  bar_cnt;
    logic [7:0]  pri;
    logic [7:0]  gnt;
    logic [2:0]  lvl_d;
    logic [3:0]  col;
    logic        unused_bits;

    assign unused_bits = ^{rng[31:4], score[3:0]};

    assign rise      = btn & ~btn_q;
    assign running   = (state != INIT) && (state != END);
    assign grav_fire = running && (grav_q == per_q - 32'd1);
    assign bar_inc   = bar_req && (state != INIT);

    // Repeat fires once the hold reaches DAS, then every ARR.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rep_fire[i] = btn[i] && (rep_q[i] == 32'(DAS_TICKS));
        end
    end

    assign pend_set = rise | {4'b0, rep_fire | {grav_fire, 2'b00}};

    always_comb begin
        lvl_d = 3'(MAX_SHIFT);
        if (score[15:8] == 8'd0 && score[7:4] < 4'(MAX_SHIFT)) begin
            lvl_d = score[6:4];
        end
    end

    assign col = (rng[3:0] >= 4'd10) ? rng[3:0] - 4'd10 : rng[3:0];

    // Priority vector, bit 0 = most urgent; gnt isolates the lowest set bit.
    assign pri = {bar_cnt != 5'd0, pend_q[2], pend_q[5], pend_q[1],
                  pend_q[0], pend_q[4], pend_q[3], pend_q[6]};
    assign gnt = pri & (~pri + 8'd1);

    always_comb begin
        fsm_d    = fsm_q;
        ctrl_d   = NONE;
        mask_d   = '0;
        pend_clr = '0;
        wake     = 1'b0;
        bar_dec  = 1'b0;
        grav_rst = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (state == WAIT && pri != 8'd0) begin
                    fsm_d = ISSUE;
                    unique case (1'b1)
                        gnt[0]: begin
                            ctrl_d      = HOLD;
                            pend_clr[6] = 1'b1;
                        end
                        gnt[1]: begin
                            ctrl_d      = ROTATE;
                            pend_clr[3] = 1'b1;
                        end
                        gnt[2]: begin
                            ctrl_d      = ROTATE_REV;
                            pend_clr[4] = 1'b1;
                        end
                        gnt[3]: begin
                            ctrl_d      = LEFT;
                            pend_clr[0] = 1'b1;
                        end
                        gnt[4]: begin
                            ctrl_d      = RIGHT;
                            pend_clr[1] = 1'b1;
                        end
                        gnt[5]: begin
                            ctrl_d      = DROP;
                            pend_clr[5] = 1'b1;
                            grav_rst    = 1'b1;
                        end
                        gnt[6]: begin
                            ctrl_d      = DOWN;
                            pend_clr[2] = 1'b1;
                            grav_rst    = 1'b1;
                        end
                        default: begin
                            ctrl_d  = BAR;
                            bar_dec = 1'b1;
                            mask_d  = 10'd1 << col;
                        end
                    endcase
                end else if (!running && rise != 7'd0) begin
                    // Any command wakes the core from INIT/END.
                    fsm_d    = ISSUE;
                    ctrl_d   = DOWN;
                    wake     = 1'b1;
                    grav_rst = 1'b1;
                end
            end
            ISSUE: fsm_d = BUSY;
            BUSY: begin
                if (state == WAIT || !running) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q    <= IDLE;
            ctrl     <= NONE;
            bar_mask <= '0;
            level    <= '0;
            btn_q    <= '0;
            pend_q   <= '0;
            grav_q   <= '0;
            per_q    <= 32'(GRAVITY_TICKS);
            bar_cnt  <= '0;
            for (int i = 0; i < 3; i++) begin
                rep_q[i] <= '0;
            end
        end else begin
            fsm_q    <= fsm_d;
            ctrl     <= ctrl_d;
            bar_mask <= mask_d;
            level    <= lvl_d;
            btn_q    <= btn;
            // A flag set in its own issue cycle survives the clear.
            pend_q   <= wake ? '0 : (pend_q & ~pend_clr) | pend_set;
            for (int i = 0; i < 3; i++) begin
                if (!btn[i]) begin
                    rep_q[i] <= '0;
                end else if (rep_fire[i]) begin
                    rep_q[i] <= 32'(DAS_TICKS - ARR_TICKS + 1);
                end else begin
                    rep_q[i] <= rep_q[i] + 32'd1;
                end
            end
            // New period only latches at a wrap.
            if (grav_fire) begin
                per_q <= 32'(GRAVITY_TICKS) >> level;
            end
            if (state == INIT || grav_rst) begin
                grav_q <= '0;
            end else if (grav_fire) begin
                grav_q <= '0;
            end else if (running) begin
                grav_q <= grav_q + 32'd1;
            end
            if (state == INIT) begin
                bar_cnt <= '0;
            end else if (bar_inc && !bar_dec) begin
                if (bar_cnt < 5'(BAR_MAX)) begin
                    bar_cnt <= bar_cnt + 5'd1;
                end
            end else if (!bar_inc && bar_dec) begin
                bar_cnt <= bar_cnt - 5'd1;
            end
        end
    end

endmodule
